// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants, state codes and helpers for the two-port data RAM arbiter.
package ram_port_arbiter_pkg;
    localparam logic [1:0] RAM_MODE_BYTE = 2'd0;
    localparam logic [1:0] RAM_MODE_HALF = 2'd1;
    localparam logic [1:0] RAM_MODE_WORD = 2'd2;

    localparam logic ARB_PORT_CPU = 1'b0;
    localparam logic ARB_PORT_DMA = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_e;

    // The unused size encoding 2'b11 behaves as a word access.
    function automatic logic [1:0] norm_mode(input logic [1:0] size);
        return (size == 2'b11) ? RAM_MODE_WORD : size;
    endfunction

    function automatic logic misaligned(input logic [1:0] mode, input logic [1:0] a);
        logic r;
        r = 1'b0;
        if (mode == RAM_MODE_HALF) r = a[0];
        else if (mode == RAM_MODE_WORD) r = (a != 2'b00);
        return r;
    endfunction
endpackage

// File: rtl/ram_port_arbiter_pick.sv
// Combinational winner select between the CPU port (0) and the loader/DMA port (1).
module arb_pick
    import ram_port_arbiter_pkg::*;
#(
    parameter int CPU_PRIO   = 0,
    parameter int STARVE_MAX = 4
) (
    input  logic [1:0] i_req,
    input  logic       i_last_owner,
    input  logic [3:0] i_starve_cnt,
    output logic       o_valid,
    output logic       o_winner
);
    always_comb begin
        o_valid  = |i_req;
        o_winner = ARB_PORT_CPU;
        if (i_req == 2'b10) begin
            o_winner = ARB_PORT_DMA;
        end else if (i_req == 2'b11) begin
            if (CPU_PRIO != 0) o_winner = (i_starve_cnt == 4'(STARVE_MAX));
            else               o_winner = ~i_last_owner;
        end
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one data RAM between the CPU load/store path and the loader/DMA port,
// one access at a time, returning load data tagged to the owning port.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int CPU_PRIO   = 0,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [1:0]    m0_size,
    input  logic          m0_signed,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [1:0]    m1_size,
    input  logic          m1_signed,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic [1:0]    ram_write_mode,
    output logic [1:0]    ram_read_mode,
    output logic          ram_read_signed,
    input  logic [DW-1:0] ram_r_data
);
    arb_state_e          r_state, w_next;
    logic                r_owner, r_last_owner, r_we, r_mis, r_signed;
    logic [3:0]          r_starve;
    logic [1:0]          r_rvalid;
    logic [1:0][DW-1:0]  r_rdata;
    logic [AW-1:0]       r_addr;
    logic [DW-1:0]       r_wdata;
    logic [1:0]          r_mode;

    logic [1:0]          w_req;
    logic                w_valid, w_winner, w_pick;
    logic                w_we, w_signed;
    logic [AW-1:0]       w_addr;
    logic [DW-1:0]       w_wdata;
    logic [1:0]          w_mode;

    assign w_req = {m1_req, m0_req};

    arb_pick #(.CPU_PRIO(CPU_PRIO), .STARVE_MAX(STARVE_MAX)) u_pick (
        .i_req        (w_req),
        .i_last_owner (r_last_owner),
        .i_starve_cnt (r_starve),
        .o_valid      (w_valid),
        .o_winner     (w_winner)
    );

    always_comb begin
        w_we     = w_winner ? m1_we     : m0_we;
        w_addr   = w_winner ? m1_addr   : m0_addr;
        w_wdata  = w_winner ? m1_wdata  : m0_wdata;
        w_signed = w_winner ? m1_signed : m0_signed;
        w_mode   = norm_mode(w_winner ? m1_size : m0_size);
    end

    assign w_pick = (r_state == ARB_IDLE) && w_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ARB_IDLE;
        else     r_state <= w_next;
    end

    // A rejected (misaligned) access never reaches the RAM, so it skips RESP.
    always_comb begin
        w_next = r_state;
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        m0_err = 1'b0;
        m1_err = 1'b0;
        ram_we = 1'b0;
        case (r_state)
            ARB_IDLE: if (w_valid) w_next = ARB_ISSUE;
            ARB_ISSUE: begin
                m0_gnt = (r_owner == ARB_PORT_CPU);
                m1_gnt = (r_owner == ARB_PORT_DMA);
                m0_err = (r_owner == ARB_PORT_CPU) && r_mis;
                m1_err = (r_owner == ARB_PORT_DMA) && r_mis;
                ram_we = r_we && !r_mis;
                w_next = (r_we || r_mis) ? ARB_IDLE : ARB_RESP;
            end
            ARB_RESP: w_next = ARB_IDLE;
            default:  w_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= ARB_PORT_CPU;
            r_last_owner <= ARB_PORT_DMA;
            r_we         <= 1'b0;
            r_mis        <= 1'b0;
            r_signed     <= 1'b0;
            r_starve     <= 4'd0;
            r_rvalid     <= 2'b00;
            r_rdata      <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mode       <= RAM_MODE_BYTE;
        end else begin
            r_rvalid <= 2'b00;
            if (w_pick) begin
                r_owner  <= w_winner;
                r_we     <= w_we;
                r_addr   <= w_addr;
                r_wdata  <= w_wdata;
                r_mode   <= w_mode;
                r_signed <= w_signed;
                r_mis    <= misaligned(w_mode, w_addr[1:0]);
                if (w_winner == ARB_PORT_DMA)                    r_starve <= 4'd0;
                else if (w_req == 2'b11 && r_starve != 4'hF)     r_starve <= r_starve + 4'd1;
            end
            if (r_state == ARB_ISSUE) begin
                r_last_owner <= r_owner;
                if (!r_we && r_mis) begin
                    r_rvalid[r_owner] <= 1'b1;
                    r_rdata[r_owner]  <= '0;
                end
            end
            if (r_state == ARB_RESP) begin
                r_rvalid[r_owner] <= 1'b1;
                r_rdata[r_owner]  <= ram_r_data;
            end
        end
    end

    assign m0_rvalid       = r_rvalid[0];
    assign m1_rvalid       = r_rvalid[1];
    assign m0_rdata        = r_rdata[0];
    assign m1_rdata        = r_rdata[1];
    assign ram_addr        = r_addr;
    assign ram_wdata       = r_wdata;
    assign ram_write_mode  = r_mode;
    assign ram_read_mode   = r_mode;
    assign ram_read_signed = r_signed;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench: a round-robin and a CPU-priority arbiter, each with its own RAM stub,
// checked cycle by cycle against a transaction-level model of the port rules.
module tb_ram_port_arbiter;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  in_req [2];
    logic [1:0]  in_we  [2];
    logic [1:0]  in_sgn [2];
    logic [31:0] in_addr  [2][2];
    logic [31:0] in_wdata [2][2];
    logic [1:0]  in_size  [2][2];
    logic [31:0] ram_rdata [2];

    wire [1:0]  o_gnt [2];
    wire [1:0]  o_rv  [2];
    wire [1:0]  o_err [2];
    wire [31:0] o_rdata [2][2];
    wire        o_we  [2];
    wire [31:0] o_addr [2];
    wire [31:0] o_wdata [2];
    wire [1:0]  o_wmode [2];
    wire [1:0]  o_rmode [2];
    wire        o_rsgn [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        ram_port_arbiter #(.AW(32), .DW(32), .CPU_PRIO(k), .STARVE_MAX(SMAX)) dut (
            .clk(clk), .rst(rst),
            .m0_req(in_req[k][0]), .m0_we(in_we[k][0]), .m0_addr(in_addr[k][0]),
            .m0_wdata(in_wdata[k][0]), .m0_size(in_size[k][0]), .m0_signed(in_sgn[k][0]),
            .m0_gnt(o_gnt[k][0]), .m0_rvalid(o_rv[k][0]), .m0_rdata(o_rdata[k][0]), .m0_err(o_err[k][0]),
            .m1_req(in_req[k][1]), .m1_we(in_we[k][1]), .m1_addr(in_addr[k][1]),
            .m1_wdata(in_wdata[k][1]), .m1_size(in_size[k][1]), .m1_signed(in_sgn[k][1]),
            .m1_gnt(o_gnt[k][1]), .m1_rvalid(o_rv[k][1]), .m1_rdata(o_rdata[k][1]), .m1_err(o_err[k][1]),
            .ram_we(o_we[k]), .ram_addr(o_addr[k]), .ram_wdata(o_wdata[k]),
            .ram_write_mode(o_wmode[k]), .ram_read_mode(o_rmode[k]),
            .ram_read_signed(o_rsgn[k]), .ram_r_data(ram_rdata[k])
        );
    end

    // RAM stubs (driven by DUT outputs) and the model's own shadow memories.
    logic [7:0]  ram_mem [2][256];
    logic [7:0]  mdl_mem [2][256];
    logic [31:0] rd_pend [2];

    // Model state and per-cycle expectation slots (indexed by cycle mod 4).
    int          n;
    int          busy [2];
    int          starve [2];
    logic        last [2];
    logic [1:0]  ex_gnt [2][4];
    logic [1:0]  ex_err [2][4];
    logic [1:0]  ex_rv  [2][4];
    logic [31:0] ex_rd  [2][4];
    logic        ex_we  [2][4];
    logic        ex_acc [2][4];
    logic [31:0] ex_addr [2][4];
    logic [31:0] ex_wdata [2][4];
    logic [1:0]  ex_mode [2][4];
    logic        ex_sgn [2][4];
    logic [31:0] exp_rdata [2][2];

    int vec, miss;
    int gcnt [2][2];
    int rvcnt [2][2];
    bit rec;
    int dq0[$], dq1[$], mq0[$], mq1[$];
    int exp_rr [8]  = '{0, 1, 0, 1, 0, 1, 0, 1};
    int exp_pr [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    function automatic logic [31:0] ext(input logic [31:0] raw, input logic [1:0] mode, input logic sgn);
        case (mode)
            2'd0:    return sgn ? {{24{raw[7]}}, raw[7:0]} : {24'd0, raw[7:0]};
            2'd1:    return sgn ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    function automatic logic [31:0] mem_raw(input bit sel, input int k, input logic [31:0] addr);
        logic [7:0]  a;
        logic [31:0] r;
        a = addr[7:0];
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = sel ? ram_mem[k][8'(a + i)] : mdl_mem[k][8'(a + i)];
        return r;
    endfunction

    task automatic mem_write(input bit sel, input int k, input logic [31:0] addr,
                             input logic [31:0] d, input logic [1:0] mode);
        int nb;
        logic [7:0] a;
        a  = addr[7:0];
        nb = (mode == 2'd0) ? 1 : (mode == 2'd1) ? 2 : 4;
        for (int i = 0; i < nb; i++) begin
            if (sel) ram_mem[k][8'(a + i)] = d[8*i +: 8];
            else     mdl_mem[k][8'(a + i)] = d[8*i +: 8];
        end
    endtask

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s dut%0d cyc %0d: got %h want %h", nm, k, n, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            busy[k] = 0; starve[k] = 0; last[k] = 1'b1;
            exp_rdata[k][0] = '0; exp_rdata[k][1] = '0;
            for (int s = 0; s < 4; s++) begin
                ex_gnt[k][s] = '0; ex_err[k][s] = '0; ex_rv[k][s] = '0; ex_rd[k][s] = '0;
                ex_we[k][s] = 1'b0; ex_acc[k][s] = 1'b0; ex_addr[k][s] = '0;
                ex_wdata[k][s] = '0; ex_mode[k][s] = '0; ex_sgn[k][s] = 1'b0;
            end
        end
    endtask

    // Decide, per DUT, what the edge about to happen does to the port outputs.
    task automatic model_step();
        n++;
        for (int k = 0; k < 2; k++) begin
            if (!rst && n >= busy[k] && in_req[k] != 2'b00) begin
                int w, s;
                logic [1:0] md;
                logic mis;
                logic [31:0] a;
                if (in_req[k] == 2'b11)
                    w = (k == 1) ? ((starve[k] == SMAX) ? 1 : 0) : (last[k] ? 0 : 1);
                else
                    w = in_req[k][1] ? 1 : 0;
                if (w == 1) starve[k] = 0;
                else if (in_req[k] == 2'b11 && starve[k] < 15) starve[k]++;
                last[k] = (w == 1);
                a   = in_addr[k][w];
                md  = (in_size[k][w] == 2'd3) ? 2'd2 : in_size[k][w];
                mis = (md == 2'd1 && a[0]) || (md == 2'd2 && a[1:0] != 2'b00);
                s   = n % 4;
                ex_gnt[k][s][w] = 1'b1;
                ex_err[k][s][w] = mis;
                if (in_we[k][w]) begin
                    ex_we[k][s] = !mis; ex_addr[k][s] = a;
                    ex_wdata[k][s] = in_wdata[k][w]; ex_mode[k][s] = md;
                    if (!mis) mem_write(1'b0, k, a, in_wdata[k][w], md);
                    busy[k] = n + 2;
                end else if (mis) begin
                    ex_rv[k][(n + 1) % 4][w] = 1'b1;
                    ex_rd[k][(n + 1) % 4] = '0;
                    busy[k] = n + 2;
                end else begin
                    ex_acc[k][s] = 1'b1; ex_addr[k][s] = a;
                    ex_mode[k][s] = md; ex_sgn[k][s] = in_sgn[k][w];
                    ex_rv[k][(n + 2) % 4][w] = 1'b1;
                    ex_rd[k][(n + 2) % 4] = ext(mem_raw(1'b0, k, a), md, in_sgn[k][w]);
                    busy[k] = n + 3;
                end
                if (rec) begin
                    if (k == 0) mq0.push_back(w);
                    else        mq1.push_back(w);
                end
            end
        end
    endtask

    task automatic compare();
        int s;
        s = n % 4;
        for (int k = 0; k < 2; k++) begin
            chk("gnt", k, 32'(o_gnt[k]), 32'(ex_gnt[k][s]));
            chk("err", k, 32'(o_err[k]), 32'(ex_err[k][s]));
            chk("rvalid", k, 32'(o_rv[k]), 32'(ex_rv[k][s]));
            chk("ram_we", k, 32'(o_we[k]), 32'(ex_we[k][s]));
            for (int p = 0; p < 2; p++) begin
                if (ex_rv[k][s][p]) exp_rdata[k][p] = ex_rd[k][s];
                chk(p == 0 ? "m0_rdata" : "m1_rdata", k, o_rdata[k][p], exp_rdata[k][p]);
            end
            if (ex_we[k][s]) begin
                chk("wr_addr", k, o_addr[k], ex_addr[k][s]);
                chk("wr_data", k, o_wdata[k], ex_wdata[k][s]);
                chk("wr_mode", k, 32'(o_wmode[k]), 32'(ex_mode[k][s]));
            end
            if (ex_acc[k][s]) begin
                chk("rd_addr", k, o_addr[k], ex_addr[k][s]);
                chk("rd_mode", k, 32'(o_rmode[k]), 32'(ex_mode[k][s]));
                chk("rd_sgn", k, 32'(o_rsgn[k]), 32'(ex_sgn[k][s]));
            end
            ex_gnt[k][s] = '0; ex_err[k][s] = '0; ex_rv[k][s] = '0;
            ex_we[k][s] = 1'b0; ex_acc[k][s] = 1'b0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        // RAM stub: data for the address seen this cycle appears next cycle.
        for (int k = 0; k < 2; k++) begin
            ram_rdata[k] = rd_pend[k];
            rd_pend[k]   = ext(mem_raw(1'b1, k, o_addr[k]), o_rmode[k], o_rsgn[k]);
            if (o_we[k] === 1'b1) mem_write(1'b1, k, o_addr[k], o_wdata[k], o_wmode[k]);
        end
        compare();
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (o_gnt[k][p] === 1'b1) gcnt[k][p]++;
                if (o_rv[k][p] === 1'b1)  rvcnt[k][p]++;
            end
            if (rec && o_gnt[k] != 2'b00) begin
                if (k == 0) dq0.push_back(o_gnt[k][1] ? 1 : 0);
                else        dq1.push_back(o_gnt[k][1] ? 1 : 0);
            end
        end
    endtask

    task automatic setp(input int p, input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [1:0] size, input logic sgn);
        for (int k = 0; k < 2; k++) begin
            in_req[k][p] = req; in_we[k][p] = we; in_addr[k][p] = addr;
            in_wdata[k][p] = wd; in_size[k][p] = size; in_sgn[k][p] = sgn;
        end
    endtask

    task automatic chk_zero(input string nm);
        for (int k = 0; k < 2; k++) begin
            chk({nm, "_ctl"}, k, {24'd0, o_gnt[k], o_rv[k], o_err[k], o_we[k], o_rsgn[k]}, 32'd0);
            chk({nm, "_addr"}, k, o_addr[k], 32'd0);
            chk({nm, "_wdata"}, k, o_wdata[k], 32'd0);
            chk({nm, "_modes"}, k, {28'd0, o_wmode[k], o_rmode[k]}, 32'd0);
            chk({nm, "_rdata0"}, k, o_rdata[k][0], 32'd0);
            chk({nm, "_rdata1"}, k, o_rdata[k][1], 32'd0);
        end
    endtask

    initial begin
        int g1, r0;
        vec = 0; miss = 0; n = 0; rec = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 256; i++) begin
                ram_mem[k][i] = 8'(i * 37 + 5);
                mdl_mem[k][i] = 8'(i * 37 + 5);
            end
            ram_mem[k][0] = 8'hEF; ram_mem[k][1] = 8'hBE; ram_mem[k][2] = 8'hAD; ram_mem[k][3] = 8'hDE;
            mdl_mem[k][0] = 8'hEF; mdl_mem[k][1] = 8'hBE; mdl_mem[k][2] = 8'hAD; mdl_mem[k][3] = 8'hDE;
            rd_pend[k] = '0; ram_rdata[k] = '0;
            gcnt[k][0] = 0; gcnt[k][1] = 0; rvcnt[k][0] = 0; rvcnt[k][1] = 0;
        end
        setp(0, 1'b0, 1'b0, 32'h8000, 32'h0, 2'd2, 1'b0);
        setp(1, 1'b0, 1'b0, 32'h8000, 32'h0, 2'd2, 1'b0);
        model_reset();

        // Reset state
        @(negedge clk);
        chk_zero("reset");
        tick();
        rst = 1'b0;

        // Both ports store continuously: RR alternates, priority mode lets DMA in every 5th.
        setp(0, 1'b1, 1'b1, 32'h8040, 32'h11111111, 2'd2, 1'b0);
        setp(1, 1'b1, 1'b1, 32'h8080, 32'h22222222, 2'd2, 1'b0);
        rec = 1'b1;
        repeat (24) tick();
        rec = 1'b0;
        setp(0, 1'b0, 1'b0, 32'h8000, 32'h0, 2'd2, 1'b0);
        setp(1, 1'b0, 1'b0, 32'h8000, 32'h0, 2'd2, 1'b0);
        repeat (3) tick();
        chk("rr_count", 0, (dq0.size() >= 8) ? 32'd1 : 32'd0, 32'd1);
        chk("pr_count", 1, (dq1.size() >= 10) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < 8 && i < dq0.size(); i++) chk("rr_order", 0, 32'(dq0[i]), 32'(exp_rr[i]));
        for (int i = 0; i < 8 && i < mq0.size(); i++) chk("rr_model", 0, 32'(mq0[i]), 32'(exp_rr[i]));
        for (int i = 0; i < 10 && i < dq1.size(); i++) chk("pr_order", 1, 32'(dq1[i]), 32'(exp_pr[i]));
        for (int i = 0; i < 10 && i < mq1.size(); i++) chk("pr_model", 1, 32'(mq1[i]), 32'(exp_pr[i]));

        rst = 1'b1; model_reset();
        tick();
        rst = 1'b0;

        // Port 0 word load from 0x8000: gnt next cycle, data two cycles later.
        setp(0, 1'b1, 1'b0, 32'h8000, 32'h0, 2'd2, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) chk("t1_gnt", k, 32'(o_gnt[k]), 32'd1);
        setp(0, 1'b0, 1'b0, 32'h8000, 32'h0, 2'd2, 1'b0);
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            chk("t1_rvalid", k, 32'(o_rv[k]), 32'd1);
            chk("t1_rdata", k, o_rdata[k][0], 32'hDEADBEEF);
        end
        tick();

        // Misaligned half store on port 1 is rejected and leaves the RAM alone.
        setp(1, 1'b1, 1'b1, 32'h8001, 32'hCAFEF00D, 2'd1, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("t4_gnt", k, 32'(o_gnt[k]), 32'd2);
            chk("t4_err", k, 32'(o_err[k]), 32'd2);
            chk("t4_we", k, 32'(o_we[k]), 32'd0);
        end
        setp(1, 1'b0, 1'b0, 32'h8000, 32'h0, 2'd2, 1'b0);
        tick();
        setp(0, 1'b1, 1'b0, 32'h8000, 32'h0, 2'd3, 1'b0);
        tick();
        setp(0, 1'b0, 1'b0, 32'h8000, 32'h0, 2'd2, 1'b0);
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            chk("t4_rdata", k, o_rdata[k][0], 32'hDEADBEEF);
            chk("t4_mem", k, {16'd0, ram_mem[k][2], ram_mem[k][1]}, 32'h0000ADBE);
        end
        tick();

        // Reset during RESP of a port 0 load: outputs clear at once, no rvalid later.
        setp(0, 1'b1, 1'b0, 32'h8004, 32'h0, 2'd2, 1'b1);
        tick();
        setp(0, 1'b0, 1'b0, 32'h8000, 32'h0, 2'd2, 1'b0);
        tick();
        r0 = rvcnt[0][0] + rvcnt[1][0];
        rst = 1'b1;
        #1;
        chk_zero("t5_async");
        model_reset();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("t5_no_rvalid", 0, 32'(rvcnt[0][0] + rvcnt[1][0] - r0), 32'd0);

        // Port 1 raises and withdraws its request while port 0's load is busy.
        setp(0, 1'b1, 1'b0, 32'h8008, 32'h0, 2'd2, 1'b0);
        tick();
        g1 = gcnt[0][1] + gcnt[1][1];
        setp(0, 1'b0, 1'b0, 32'h8000, 32'h0, 2'd2, 1'b0);
        setp(1, 1'b1, 1'b1, 32'h8010, 32'h33333333, 2'd2, 1'b0);
        tick();
        setp(1, 1'b0, 1'b0, 32'h8000, 32'h0, 2'd2, 1'b0);
        repeat (3) tick();
        chk("t6_withdraw", 0, 32'(gcnt[0][1] + gcnt[1][1] - g1), 32'd0);

        // Randomized traffic: hold until gnt, occasional withdraw, mixed sizes.
        repeat (1500) begin
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < 2; p++) begin
                    if (in_req[k][p] && (o_gnt[k][p] || $urandom_range(0, 9) == 0))
                        in_req[k][p] = 1'b0;
                    if (!in_req[k][p] && $urandom_range(0, 2) == 0) begin
                        logic [31:0] a;
                        logic [1:0]  sz;
                        sz = 2'($urandom_range(0, 3));
                        a  = 32'h8000 | 32'($urandom_range(0, 255));
                        if ($urandom_range(0, 3) != 0)
                            a = (sz == 2'd0) ? a : (sz == 2'd1) ? (a & ~32'd1) : (a & ~32'd3);
                        in_req[k][p] = 1'b1;
                        in_we[k][p] = 1'($urandom_range(0, 1));
                        in_addr[k][p] = a;
                        in_wdata[k][p] = $urandom;
                        in_size[k][p] = sz;
                        in_sgn[k][p] = 1'($urandom_range(0, 1));
                    end
                end
            end
            tick();
        end
        setp(0, 1'b0, 1'b0, 32'h8000, 32'h0, 2'd2, 1'b0);
        setp(1, 1'b0, 1'b0, 32'h8000, 32'h0, 2'd2, 1'b0);
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
